// File: rtl/gauss_pkg.sv
// Shared constants and state encoding for the 3x3 Gaussian window feeder.
package gauss_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_N = 9;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gauss_line_buf.sv
// One image line of pixels; read data is registered and returns the old contents
// when the same index is written in the same cycle.
module gauss_line_buf
  import gauss_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/gauss_window_feeder.sv
// Raster pixel stream to 3x3 window handshake for the Gaussian filter.
// Optional GAUSS_WIN_STATS_EN adds win_cnt_o, a per-frame count of completed windows.
module gauss_window_feeder
  import gauss_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i_w,
  input  logic             rst_i_w,
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] win_o_0,
  output logic [PIX_W-1:0] win_o_1,
  output logic [PIX_W-1:0] win_o_2,
  output logic [PIX_W-1:0] win_o_3,
  output logic [PIX_W-1:0] win_o_4,
  output logic [PIX_W-1:0] win_o_5,
  output logic [PIX_W-1:0] win_o_6,
  output logic [PIX_W-1:0] win_o_7,
  output logic [PIX_W-1:0] win_o_8,
  output logic             win_en_o,
  input  logic             win_done_i,
  output logic             frame_done_o,
  output logic             err_o
`ifdef GAUSS_WIN_STATS_EN
  ,
  output logic [15:0]      win_cnt_o
`endif
);
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam int TW = cnt_w(TIMEOUT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e           state_reg, state_next;
  logic [CW-1:0]    col_reg, col_next;
  logic [RW-1:0]    row_reg, row_next;
  logic [TW-1:0]    tmo_reg;
  logic             last_reg;
  logic             ready_reg, ready_next;
  logic             en_reg, en_next;
  logic             fdone_reg, fdone_next;
  logic             err_reg, err_next;
  logic [PIX_W-1:0] win_reg [WIN_N];
  logic [PIX_W-1:0] col_in [3];
  logic [PIX_W-1:0] line1_q, line2_q;
  logic             accept, complete, timed_out;

  assign accept    = pix_valid_i && ready_reg;
  assign complete  = accept && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
  assign timed_out = (state_reg == ISSUE) && !win_done_i && (tmo_reg == TMO_LAST);

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
    if (state_reg == GAP && last_reg) begin
      col_next = '0;
      row_next = '0;
    end
  end

  // Reads are addressed with the upcoming column so the registered line data
  // is already waiting when the next pixel at that column arrives.
  gauss_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_line1 (
    .clk     (clk_i_w),
    .wr_en   (accept),
    .wr_addr (col_reg),
    .wr_data (pix_i),
    .rd_addr (col_next),
    .rd_data (line1_q)
  );

  gauss_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_line2 (
    .clk     (clk_i_w),
    .wr_en   (accept),
    .wr_addr (col_reg),
    .wr_data (line1_q),
    .rd_addr (col_next),
    .rd_data (line2_q)
  );

  always_comb begin
    col_in[0] = line2_q;
    col_in[1] = line1_q;
    col_in[2] = pix_i;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (complete) state_next = ISSUE;
      ISSUE:   if (win_done_i || timed_out) state_next = GAP;
      GAP:     state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    ready_next = (state_next == FILL);
    en_next    = (state_next == ISSUE);
    fdone_next = (state_reg == ISSUE) && (state_next == GAP) && last_reg;
    err_next   = err_reg | timed_out;
  end

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      state_reg <= FILL;
      col_reg   <= '0;
      row_reg   <= '0;
      tmo_reg   <= '0;
      last_reg  <= 1'b0;
      ready_reg <= 1'b0;
      en_reg    <= 1'b0;
      fdone_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      tmo_reg   <= (state_reg == ISSUE) ? tmo_reg + 1'b1 : '0;
      if (complete) last_reg <= (row_reg == ROW_LAST) && (col_reg == COL_LAST);
      ready_reg <= ready_next;
      en_reg    <= en_next;
      fdone_reg <= fdone_next;
      err_reg   <= err_next;
    end
  end

  // Window shift register; only moves on accepted pixels, so taps hold in ISSUE/GAP.
  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      for (int i = 0; i < WIN_N; i++) win_reg[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[3*r]   <= win_reg[3*r+1];
        win_reg[3*r+1] <= win_reg[3*r+2];
        win_reg[3*r+2] <= col_in[r];
      end
    end
  end

`ifdef GAUSS_WIN_STATS_EN
  logic [15:0] win_cnt_reg;

  always_ff @(posedge clk_i_w or negedge rst_i_w) begin
    if (!rst_i_w) begin
      win_cnt_reg <= '0;
    end else if (fdone_reg) begin
      win_cnt_reg <= '0;
    end else if (state_reg == ISSUE && win_done_i && win_cnt_reg != 16'hFFFF) begin
      win_cnt_reg <= win_cnt_reg + 16'd1;
    end
  end

  assign win_cnt_o = win_cnt_reg;
`endif

  assign pix_ready_o  = ready_reg;
  assign win_en_o     = en_reg;
  assign frame_done_o = fdone_reg;
  assign err_o        = err_reg;
  assign win_o_0 = win_reg[0];
  assign win_o_1 = win_reg[1];
  assign win_o_2 = win_reg[2];
  assign win_o_3 = win_reg[3];
  assign win_o_4 = win_reg[4];
  assign win_o_5 = win_reg[5];
  assign win_o_6 = win_reg[6];
  assign win_o_7 = win_reg[7];
  assign win_o_8 = win_reg[8];
endmodule

// File: tb/tb_gauss_window_feeder.sv
// Randomized bench for gauss_window_feeder: frames are checked against windows
// computed directly from the image array.
module tb_gauss_window_feeder;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int TMO  = 24;
  localparam int NWIN = (W - 2) * (H - 2);
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pix = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic [7:0] tap [9];
  logic       win_en;
  logic       win_done = 1'b0;
  logic       frame_done;
  logic       err;
`ifdef GAUSS_WIN_STATS_EN
  logic [15:0] win_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int img [NPIX];
  bit err_exp = 1'b0;

  always #5 clk = ~clk;

  gauss_window_feeder #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TMO)) dut (
    .clk_i_w      (clk),
    .rst_i_w      (rst_n),
    .pix_i        (pix),
    .pix_valid_i  (pix_valid),
    .pix_ready_o  (pix_ready),
    .win_o_0      (w0),
    .win_o_1      (w1),
    .win_o_2      (w2),
    .win_o_3      (w3),
    .win_o_4      (w4),
    .win_o_5      (w5),
    .win_o_6      (w6),
    .win_o_7      (w7),
    .win_o_8      (w8),
    .win_en_o     (win_en),
    .win_done_i   (win_done),
    .frame_done_o (frame_done),
    .err_o        (err)
`ifdef GAUSS_WIN_STATS_EN
    ,
    .win_cnt_o    (win_cnt)
`endif
  );

  always_comb begin
    tap[0] = w0; tap[1] = w1; tap[2] = w2;
    tap[3] = w3; tap[4] = w4; tap[5] = w5;
    tap[6] = w6; tap[7] = w7; tap[8] = w8;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    int nz = 0;
    for (int k = 0; k < 9; k++) if (tap[k] !== 8'd0) nz++;
    check({tag, "_taps"}, nz, 0);
    check({tag, "_en"}, win_en, 0);
    check({tag, "_ready"}, pix_ready, 0);
    check({tag, "_fdone"}, frame_done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    win_done  = 1'b0;
    err_exp   = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", pix_ready, 1);
    $display("reset applied and released");
  endtask

  // mode: 0 ramp 0..NPIX-1, 1 random, 2 constant 100; abort_at>0 resets on that window.
  task automatic run_frame(input int mode, input int vprob, input int dmin, input int dmax,
                           input bit nodone, input int abort_at);
    int acc = 0, wexp = 0, cd = 0, issue_cyc = 0, done_cnt = 0, budget = 0;
    int r, c, diff;
    bit acc_last = 0, gap_next = 0, in_issue = 0, gap_prev = 0, finished = 0, new_win;
    logic [7:0] held [9];
    for (int p = 0; p < NPIX; p++)
      img[p] = (mode == 0) ? p : (mode == 1) ? int'($urandom_range(0, 255)) : 100;
    while (!finished) begin
      @(negedge clk);
      budget++;
      if (budget > 4000) begin
        check("cycle_budget", 1, 0);
        break;
      end
      new_win = 0;
      if (acc_last) begin
        if (acc / W >= 2 && acc % W >= 2) new_win = 1;
        acc++;
      end
      if (gap_next) begin
        check("gap_en", win_en, 0);
        check("gap_ready", pix_ready, 0);
        check("gap_frame_done", frame_done, (wexp == NWIN));
        check("gap_err", err, err_exp);
`ifdef GAUSS_WIN_STATS_EN
        if (wexp == NWIN) check("win_cnt_final", win_cnt, done_cnt);
`endif
        in_issue = 0;
        gap_next = 0;
        gap_prev = 1;
      end else if (new_win) begin
        check("en_rise", win_en, 1);
        r = 2 + wexp / (W - 2);
        c = 2 + wexp % (W - 2);
        check("win_pos", acc - 1, r * W + c);
        for (int k = 0; k < 9; k++)
          check($sformatf("w%0d_tap%0d", wexp, k), tap[k], img[(r - 2 + k / 3) * W + (c - 2 + k % 3)]);
        $display("window %0d at row %0d col %0d taps %0d %0d %0d %0d %0d %0d %0d %0d %0d",
                 wexp, r, c, tap[0], tap[1], tap[2], tap[3], tap[4], tap[5], tap[6], tap[7], tap[8]);
        held      = tap;
        in_issue  = 1;
        issue_cyc = 1;
        cd        = $urandom_range(dmin, dmax);
        wexp++;
        if (wexp == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("abort");
          $display("reset asserted during window %0d", wexp);
          return;
        end
      end else if (in_issue) begin
        check("en_hold", win_en, 1);
        diff = 0;
        for (int k = 0; k < 9; k++) if (tap[k] !== held[k]) diff++;
        check("taps_stable", diff, 0);
        issue_cyc++;
      end else begin
        check("en_idle", win_en, 0);
        check("ready_fill", pix_ready, 1);
        check("frame_done_idle", frame_done, 0);
        if (gap_prev && wexp == NWIN) begin
`ifdef GAUSS_WIN_STATS_EN
          check("win_cnt_cleared", win_cnt, 0);
`endif
          check("pix_count", acc, NPIX);
          finished = 1;
        end
        gap_prev = 0;
      end

      win_done = 1'b0;
      if (in_issue) begin
        if (nodone) begin
          if (issue_cyc == TMO) begin
            gap_next = 1;
            err_exp  = 1'b1;
          end
        end else if (cd == 0) begin
          win_done = 1'b1;
          gap_next = 1;
          done_cnt++;
        end else begin
          cd--;
        end
      end else if (!gap_next && $urandom_range(0, 7) == 0) begin
        win_done = 1'b1;
      end

      acc_last = 0;
      if (acc < NPIX) begin
        pix = img[acc][7:0];
        if (!in_issue) pix_valid = ($urandom_range(1, 100) <= vprob);
        acc_last = pix_valid && pix_ready;
      end else begin
        pix_valid = 1'b0;
      end
    end
    pix_valid = 1'b0;
    win_done  = 1'b0;
    $display("frame mode %0d done: windows %0d dones %0d", mode, wexp, done_cnt);
  endtask

  initial begin
    apply_reset();
    run_frame(0, 100, 20, 20, 0, 0);
    run_frame(1, 50, 0, 6, 0, 0);
    run_frame(1, 70, 0, 0, 1, 0);
    run_frame(1, 80, 0, 3, 0, 3);
    apply_reset();
    run_frame(2, 50, 0, 4, 0, 0);
    run_frame(1, 30, 0, 2, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
